// File: rtl/program_loader.sv
// UART byte stream to instruction-memory writer; holds the pipeline in reset while loading.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int unsigned ADDR_W         = 8,
  parameter logic [31:0] END_WORD       = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              wr_instruction,
  output logic [31:0]       data_instruction,
  output logic [ADDR_W-1:0] wr_address,
  output logic              soft_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam int unsigned       TW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0]     TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] AMAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q;
  logic [1:0]        idx_q;
  logic [31:0]       shift_q;
  logic              full_q;
  logic [ADDR_W-1:0] addr_q;
  logic [TW-1:0]     tmo_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      shift_q          <= '0;
      full_q           <= 1'b0;
      addr_q           <= '0;
      tmo_q            <= '0;
      wr_instruction   <= 1'b0;
      data_instruction <= '0;
      wr_address       <= '0;
      soft_rst         <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      word_count       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q            <= '0;
`endif
    end else begin
      wr_instruction <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q    <= S_LOAD;
            addr_q     <= '0;
            word_count <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            full_q     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            soft_rst   <= 1'b0;
            busy       <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q      <= '0;
`endif
          end
        end
        S_LOAD: begin
          full_q <= rx_valid && (idx_q == 2'd3);
          if (rx_valid) begin
            shift_q <= {shift_q[23:0], rx_data};
            idx_q   <= idx_q + 2'd1;
            tmo_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            xor_q   <= xor_q ^ rx_data;
`endif
          end else if (tmo_q == TMAX) begin
            state_q <= S_ERR;
            error   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
          // full_q marks the cycle after the 4th byte: emit the word now
          if (full_q) begin
            data_instruction <= shift_q;
            wr_address       <= addr_q;
            wr_instruction   <= 1'b1;
            word_count       <= word_count + 1'b1;
            if (shift_q == END_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              if (rx_valid) begin
                busy <= 1'b0;
                if (rx_data == xor_q) begin
                  state_q  <= S_DONE;
                  done     <= 1'b1;
                  soft_rst <= 1'b1;
                end else begin
                  state_q <= S_ERR;
                  error   <= 1'b1;
                end
              end else begin
                state_q <= S_CHK;
                tmo_q   <= '0;
              end
`else
              state_q  <= S_DONE;
              done     <= 1'b1;
              soft_rst <= 1'b1;
              busy     <= 1'b0;
`endif
            end else if (addr_q == AMAX) begin
              state_q <= S_ERR;
              error   <= 1'b1;
              busy    <= 1'b0;
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (rx_data == xor_q) begin
              state_q  <= S_DONE;
              done     <= 1'b1;
              soft_rst <= 1'b1;
            end else begin
              state_q <= S_ERR;
              error   <= 1'b1;
            end
          end else if (tmo_q == TMAX) begin
            state_q <= S_ERR;
            error   <= 1'b1;
            busy    <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes queued by stimulus, popped by a monitor.
// Honours PROGRAM_LOADER_CHECKSUM_EN by appending the XOR byte after each marker.
module tb_program_loader;

  localparam int AW = 2;
  localparam int TO = 16;

  logic          clk      = 1'b0;
  logic          rst      = 1'b0;
  logic          start    = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data  = '0;
  logic          wr_instruction;
  logic [31:0]   data_instruction;
  logic [AW-1:0] wr_address;
  logic          soft_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;

  always #5 clk = ~clk;

  program_loader #(
    .ADDR_W(AW),
    .END_WORD(32'hFFFF_FFFF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .wr_instruction(wr_instruction),
    .data_instruction(data_instruction),
    .wr_address(wr_address),
    .soft_rst(soft_rst),
    .busy(busy),
    .done(done),
    .error(error),
    .word_count(word_count)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        e;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] xsum;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && wr_instruction) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %h required none",
                 wr_address, data_instruction);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_address), 64'(e.a));
        chk("wr_data", 64'(data_instruction), 64'(e.d));
      end
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xsum = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    xsum     = xsum ^ b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a);
    logic [31:0] t;
    exp_q.push_back('{a: a, d: w});
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic send_b2b(input logic [31:0] w0, input logic [31:0] w1);
    logic [63:0] t;
    exp_q.push_back('{a: 2'd0, d: w0});
    exp_q.push_back('{a: 2'd1, d: w1});
    t = {w0, w1};
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_valid = 1'b1;
      rx_data  = t[63:56];
      xsum     = xsum ^ t[63:56];
      t = t << 8;
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_marker(input logic [AW-1:0] a, input bit good);
    logic [7:0] c;
    send_word(32'hFFFF_FFFF, a);
    c = good ? xsum : ~xsum;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(c);
`else
    if (!good) c = '0;
`endif
  endtask

  task automatic wait_end(input string name);
    int k;
    k = 0;
    while (!done && !error && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk(name, 64'(k < 60), 64'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wr"},    64'(wr_instruction),   64'd0);
    chk({tag, "_data"},  64'(data_instruction), 64'd0);
    chk({tag, "_addr"},  64'(wr_address),       64'd0);
    chk({tag, "_soft"},  64'(soft_rst),         64'd1);
    chk({tag, "_busy"},  64'(busy),             64'd0);
    chk({tag, "_done"},  64'(done),             64'd0);
    chk({tag, "_error"}, 64'(error),            64'd0);
    chk({tag, "_wc"},    64'(word_count),       64'd0);
  endtask

  initial begin
    xsum = '0;
    repeat (2) @(negedge clk);
    chk_reset("rst0");
    rst = 1'b1;

    // single word, then complete the program with a marker
    do_start();
    send_word(32'h2008_0005, 2'd0);
    chk("wr_early", 64'(wr_instruction), 64'd0);
    @(negedge clk);
    chk("wr_latency", 64'(wr_instruction), 64'd1);
    chk("t1_wc",   64'(word_count), 64'd1);
    chk("t1_busy", 64'(busy),       64'd1);
    chk("t1_soft", 64'(soft_rst),   64'd0);
    send_word(32'h8C09_0004, 2'd1);
    send_word(32'h0109_5020, 2'd2);
    send_marker(2'd3, 1'b1);
    wait_end("t2_bound");
    chk("t2_done",  64'(done),       64'd1);
    chk("t2_error", 64'(error),      64'd0);
    chk("t2_soft",  64'(soft_rst),   64'd1);
    chk("t2_busy",  64'(busy),       64'd0);
    chk("t2_wc",    64'(word_count), 64'd4);

    // back-to-back bytes, then a partial word and silence
    do_start();
    send_b2b(32'h1122_3344, 32'h5566_7788);
    send_byte(8'hAA);
    send_byte(8'hBB);
    repeat (TO - 1) @(negedge clk);
    chk("tmo_early", 64'(error), 64'd0);
    @(negedge clk);
    chk("tmo_error", 64'(error),      64'd1);
    chk("tmo_soft",  64'(soft_rst),   64'd0);
    chk("tmo_busy",  64'(busy),       64'd0);
    chk("tmo_wc",    64'(word_count), 64'd2);

    // retry after error
    do_start();
    chk("retry_clr", 64'(error), 64'd0);
    send_word(32'h2402_0001, 2'd0);
    send_marker(2'd1, 1'b1);
    wait_end("retry_bound");
    chk("retry_done", 64'(done), 64'd1);

    // start ignored while loading, then reset mid-load
    do_start();
    send_word(32'h3C01_1234, 2'd0);
    do_start();
    send_byte(8'h12);
    send_byte(8'h34);
    chk("start_ign_wc",   64'(word_count), 64'd1);
    chk("start_ign_busy", 64'(busy),       64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset("rst_mid");
    rst = 1'b1;
    do_start();
    send_word(32'hAABB_CCDD, 2'd0);
    send_marker(2'd1, 1'b1);
    wait_end("fresh_bound");
    chk("fresh_done", 64'(done),       64'd1);
    chk("fresh_wc",   64'(word_count), 64'd2);

    // overflow: four non-marker words fill a 4-word memory
    do_start();
    for (int k = 0; k < 4; k++)
      send_word(32'h0101_0101 * (k + 1), AW'(k));
    wait_end("ovf_bound");
    chk("ovf_error", 64'(error),      64'd1);
    chk("ovf_done",  64'(done),       64'd0);
    chk("ovf_soft",  64'(soft_rst),   64'd0);
    chk("ovf_wc",    64'(word_count), 64'd4);
    for (int k = 0; k < 4; k++) send_byte(8'h42);
    repeat (3) @(negedge clk);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    do_start();
    send_word(32'h1234_5678, 2'd0);
    send_marker(2'd1, 1'b0);
    wait_end("csum_bound");
    chk("csum_bad_error", 64'(error), 64'd1);
    chk("csum_bad_done",  64'(done),  64'd0);
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stall required completion");
    $fatal(1);
  end

endmodule
